m_s_to_p: RTL and testbench
===========================

M_S_TO_P -- requirements
Module: m_s_to_p

Interface
REQ-001 Parameter: WORD, default 8, received word width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 start  input  1  frame qualifier; held high by transmitter for a whole word, low between words.
REQ-005 data_i  input  1  serial data, MSB first, one bit per clk.
REQ-006 out_ready  input  1  consumer can accept data_out this cycle.
REQ-007 clr_err  input  1  clears overrun flag.
REQ-008 data_out  output  WORD  last completed word, held until accepted.
REQ-009 out_valid  output  1  data_out holds an unconsumed word.
REQ-010 done  output  1  one-cycle pulse, word completed.
REQ-011 frame_err  output  1  one-cycle pulse, start dropped mid-word.
REQ-012 overrun  output  1  sticky; word completed while holding register full.

Function
REQ-013 FSM states IDLE, ALIGN, SHIFT, WAIT_LOW; 2-bit encoding.
REQ-014 IDLE: start=1 -> ALIGN; no sample taken (absorbs one-cycle transmitter output latency).
REQ-015 ALIGN: start=1 -> SHIFT, bit counter=0, shift register=0; start=0 -> IDLE, no error.
REQ-016 SHIFT: each edge, shift register <= {shift[WORD-2:0], data_i}; counter +1.
REQ-017 Counter width $clog2(WORD+1); word complete on the edge where counter goes WORD-1 -> WORD.
REQ-018 Completion edge: done=1 for that cycle; state -> WAIT_LOW; word offered to holding register.
REQ-019 Holding register: loads completed word if empty, or if being drained (out_valid && out_ready) on the same edge.
REQ-020 Holding register full and not drained at completion: word dropped, data_out unchanged, overrun set.
REQ-021 out_valid && out_ready on an edge clears out_valid unless a new word loads on that edge (out_valid stays 1, data_out updates).
REQ-022 SHIFT with start=0: partial word discarded, frame_err pulses, state -> IDLE, holding register unaffected.
REQ-023 WAIT_LOW: start=0 -> IDLE; start=1 remains WAIT_LOW; data_i ignored.
REQ-024 Latency: start first sampled high at edge E0 -> samples at E2..E(WORD+1); out_valid and done at E(WORD+1).
REQ-025 overrun clears on clr_err=1 unless a new overrun occurs the same edge (set wins).
REQ-026 data_out, out_valid change only as in REQ-019..021; never driven from partial words.

Reset
REQ-027 reset=1 on an edge: state IDLE, counter 0, shift register 0, data_out 0, out_valid 0, done 0, frame_err 0, overrun 0.
REQ-028 Reset overrides all inputs including mid-word, in WAIT_LOW, or with holding register full; pending word lost.
REQ-029 No initial blocks relied on for functional reset; outputs undefined only before first reset edge.

Structure
REQ-030 Shared package/header m_serial_pkg holds: default WORD, FSM state encodings, counter-width function; shared with the parallel-to-serial transmitter m_p_to_s.
REQ-031 One sub-module m_s_to_p_hold: one-entry output buffer (load, drain, full, overrun detect); FSM and shifter stay in top.
REQ-032 All registers non-blocking, single always block per register group; no latches.

Verification
REQ-033 Loopback with m_p_to_s, WORD=8, data 8'hA5, out_ready=1 -> data_out=8'hA5, out_valid and done at E9, no errors.
REQ-034 Two back-to-back words 8'h3C, 8'hC3 with out_ready=0 throughout -> data_out=8'h3C held, overrun=1 after second completion; clr_err=1 -> overrun=0.
REQ-035 Second word completes same edge out_ready=1 drains first -> data_out=8'hC3, out_valid stays 1, overrun=0.
REQ-036 start dropped after 4 bits of 8'hFF -> frame_err one-cycle pulse, state IDLE, out_valid unchanged; next word 8'h81 received correctly.
REQ-037 reset=1 asserted after 5 bits, and separately with out_valid=1 -> all outputs 0 next cycle; subsequent word 8'h5A received correctly.
REQ-038 WORD=16, data 16'hBEEF -> data_out=16'hBEEF at E17.

Source files
------------

// File: rtl/m_serial_pkg.sv
// Shared definitions for the serial link pair m_s_to_p / m_p_to_s:
// default word width, FSM state encoding and bit-counter width helper.
package m_serial_pkg;

  localparam int unsigned WORD_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALIGN    = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  // Counter must be able to hold the value WORD itself
  function automatic int unsigned cnt_width(input int unsigned word);
    return $clog2(word + 1);
  endfunction

endpackage

// File: rtl/m_s_to_p_hold.sv
// One-entry output buffer: captures completed words, releases them on
// out_ready, and flags a sticky overrun when a word arrives while full.
module m_s_to_p_hold import m_serial_pkg::*; #(
  parameter int unsigned WORD = WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WORD-1:0] load_data,
  input  logic            out_ready,
  input  logic            clr_err,
  output logic [WORD-1:0] data_out,
  output logic            out_valid,
  output logic            overrun
);

  logic [WORD-1:0] data_r;
  logic            valid_r;
  logic            overrun_r;
  logic            drain_s;
  logic            accept_s;
  logic            lost_s;

  // a drain on the same edge frees the slot for the incoming word
  always_comb begin
    drain_s = valid_r & out_ready;
    if (load && (!valid_r || drain_s)) begin
      accept_s = 1'b1;
      lost_s   = 1'b0;
    end else if (load) begin
      accept_s = 1'b0;
      lost_s   = 1'b1;
    end else begin
      accept_s = 1'b0;
      lost_s   = 1'b0;
    end
  end

  // buffer contents, valid flag and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (accept_s) begin
        data_r  <= load_data;
        valid_r <= 1'b1;
      end else if (drain_s) begin
        valid_r <= 1'b0;
      end
      if (lost_s) begin
        overrun_r <= 1'b1;
      end else if (clr_err) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign data_out  = data_r;
  assign out_valid = valid_r;
  assign overrun   = overrun_r;

endmodule

// File: rtl/m_s_to_p.sv
// Serial-to-parallel receiver: framed by start, MSB first, with a one-cycle
// alignment slot before the first sample and a one-entry output buffer.
module m_s_to_p import m_serial_pkg::*; #(
  parameter int unsigned WORD = WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            data_i,
  input  logic            out_ready,
  input  logic            clr_err,
  output logic [WORD-1:0] data_out,
  output logic            out_valid,
  output logic            done,
  output logic            frame_err,
  output logic            overrun
);

  localparam int unsigned     CW       = cnt_width(WORD);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WORD - 1);

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [WORD-1:0] shift_r;
  logic            done_r;
  logic            frame_err_r;
  logic [WORD-1:0] word_s;
  logic            complete_s;

  // completed word is formed combinationally so the buffer loads on the completion edge
  always_comb begin
    word_s = {shift_r[WORD-2:0], data_i};
    if ((state_r == ST_SHIFT) && start && (cnt_r == LAST_CNT)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
  end

  // framing FSM, bit counter, shifter and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      shift_r     <= '0;
      done_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) state_r <= ST_ALIGN;
        end
        ST_ALIGN: begin
          if (start) begin
            state_r <= ST_SHIFT;
            cnt_r   <= '0;
            shift_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (!start) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
          end else begin
            shift_r <= word_s;
            cnt_r   <= cnt_r + CW'(1'b1);
            if (complete_s) begin
              done_r  <= 1'b1;
              state_r <= ST_WAIT_LOW;
            end
          end
        end
        ST_WAIT_LOW: begin
          if (!start) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  m_s_to_p_hold #(.WORD(WORD)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (complete_s),
    .load_data (word_s),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign done      = done_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_m_s_to_p.sv
// Self-checking bench for m_s_to_p: frame-level reference model with a
// queue-based output buffer, directed scenarios plus randomized frames.
module tb_m_s_to_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, data_i, out_ready, clr_err;
  logic [7:0] data_out;
  logic       out_valid, done, frame_err, overrun;

  logic        start16, data16, ready16, clr16;
  logic [15:0] data_out16;
  logic        out_valid16, done16, frame_err16, overrun16;

  m_s_to_p dut (
    .clk(clk), .reset(reset), .start(start), .data_i(data_i),
    .out_ready(out_ready), .clr_err(clr_err), .data_out(data_out),
    .out_valid(out_valid), .done(done), .frame_err(frame_err), .overrun(overrun)
  );

  m_s_to_p #(.WORD(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .data_i(data16),
    .out_ready(ready16), .clr_err(clr16), .data_out(data_out16),
    .out_valid(out_valid16), .done(done16), .frame_err(frame_err16), .overrun(overrun16)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int edge_mism = 0;
  int done_cnt = 0;
  int last_done_at = -1;
  int last_ferr_at = -1;

  // reference model: buffer as a queue of at most one word
  logic [7:0] exp_q[$];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ovr  = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_ferr = 1'b0;

  function automatic logic pick_rdy(input int mode, input logic last);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom);
      default: return last;
    endcase
  endfunction

  function automatic logic pick_clr(input bit rclr);
    if (rclr) return ($urandom_range(0, 5) == 0);
    else return 1'b0;
  endfunction

  // one clock edge: drive inputs, advance the model, compare every output
  task automatic step(input logic s, input logic d, input logic rdy, input logic clr,
                      input logic rst, input logic comp, input logic abrt, input logic [7:0] w);
    bit drained, lost;
    start = s; data_i = d; out_ready = rdy; clr_err = clr; reset = rst;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      exp_q.delete();
      exp_dout = 8'h00; exp_ovr = 1'b0; exp_done = 1'b0; exp_ferr = 1'b0;
    end else begin
      drained = (exp_q.size() != 0) && rdy;
      lost    = comp && (exp_q.size() != 0) && !drained;
      if (drained) exp_q.delete();
      if (comp && !lost) begin
        exp_q.push_back(w);
        exp_dout = w;
      end
      if (lost) exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      exp_done = comp;
      exp_ferr = abrt;
    end
    #1;
    if (done === 1'b1) begin
      last_done_at = edge_cnt;
      done_cnt++;
    end
    if (frame_err === 1'b1) last_ferr_at = edge_cnt;
    if ({data_out, out_valid, done, frame_err, overrun} !==
        {exp_dout, (exp_q.size() != 0), exp_done, exp_ferr, exp_ovr}) begin
      edge_mism++;
      if (edge_mism == 1)
        $display("  edge %0d differs: dut d=%h v=%b dn=%b fe=%b ov=%b, model d=%h v=%b dn=%b fe=%b ov=%b",
                 edge_cnt, data_out, out_valid, done, frame_err, overrun,
                 exp_dout, (exp_q.size() != 0), exp_done, exp_ferr, exp_ovr);
    end
  endtask

  // one transmitter frame; nbits<0 drops start in the alignment slot
  task automatic drive_frame(input logic [7:0] w, input int nbits, input int mode, input bit rclr,
                             input bit end_reset, input int hold, output int e0);
    step(1'b1, 1'($urandom), pick_rdy(mode, 1'b0), pick_clr(rclr), 1'b0, 1'b0, 1'b0, w);
    e0 = edge_cnt;
    if (nbits < 0) begin
      step(1'b0, 1'($urandom), pick_rdy(mode, 1'b0), pick_clr(rclr), 1'b0, 1'b0, 1'b0, w);
      return;
    end
    step(1'b1, 1'($urandom), pick_rdy(mode, 1'b0), pick_clr(rclr), 1'b0, 1'b0, 1'b0, w);
    for (int i = 0; i < nbits; i++)
      step(1'b1, w[7-i], pick_rdy(mode, (i == 7)), pick_clr(rclr), 1'b0, (i == 7), 1'b0, w);
    if (end_reset) begin
      step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, w);
    end else if (nbits < 8) begin
      step(1'b0, 1'($urandom), pick_rdy(mode, 1'b0), pick_clr(rclr), 1'b0, 1'b0, 1'b1, w);
    end else begin
      for (int k = 0; k < hold; k++)
        step(1'b1, 1'($urandom), pick_rdy(mode, 1'b0), pick_clr(rclr), 1'b0, 1'b0, 1'b0, w);
      step(1'b0, 1'($urandom), pick_rdy(mode, 1'b0), pick_clr(rclr), 1'b0, 1'b0, 1'b0, w);
    end
  endtask

  task automatic test_reset;
    edge_mism = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_tests++; if ({out_valid, done, frame_err, overrun} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {out_valid, done, frame_err, overrun}); end
    n_tests++; if ({data_out16, out_valid16, done16, frame_err16, overrun16} !== 20'h00000) begin
      n_fail++; $display("FAIL reset_w16: got %h/%b want 0000/0", data_out16, {out_valid16, done16, frame_err16, overrun16}); end
  endtask

  task automatic test_loopback;
    int e0, ferr0;
    edge_mism = 0; ferr0 = last_ferr_at;
    drive_frame(8'hA5, 8, 1, 1'b0, 1'b0, 0, e0);
    n_tests++; if (last_done_at !== e0 + 9) begin n_fail++; $display("FAIL loop_done_edge: got E%0d want E9", last_done_at - e0); end
    n_tests++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL loop_data: got %h want a5", data_out); end
    n_tests++; if (last_ferr_at !== ferr0 || overrun !== 1'b0) begin n_fail++; $display("FAIL loop_errors: ferr_at %0d ovr %b want none", last_ferr_at, overrun); end
    n_tests++; if (edge_mism !== 0) begin n_fail++; $display("FAIL loop_edges: got %0d differing edges want 0", edge_mism); end
  endtask

  task automatic test_overrun;
    int e0;
    edge_mism = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive_frame(8'h3C, 8, 0, 1'b0, 1'b0, 0, e0);
    drive_frame(8'hC3, 8, 0, 1'b0, 1'b0, 0, e0);
    n_tests++; if ({data_out, out_valid, overrun} !== {8'h3C, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovr_set: got d=%h v=%b ov=%b want 3c 1 1", data_out, out_valid, overrun); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_tests++; if ({data_out, out_valid, overrun} !== {8'h3C, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ovr_clear: got d=%h v=%b ov=%b want 3c 1 0", data_out, out_valid, overrun); end
    n_tests++; if (edge_mism !== 0) begin n_fail++; $display("FAIL ovr_edges: got %0d differing edges want 0", edge_mism); end
  endtask

  task automatic test_drain_same_edge;
    int e0;
    edge_mism = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive_frame(8'h3C, 8, 0, 1'b0, 1'b0, 0, e0);
    drive_frame(8'hC3, 8, 3, 1'b0, 1'b0, 0, e0);
    n_tests++; if ({data_out, out_valid, overrun} !== {8'hC3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL drain_load: got d=%h v=%b ov=%b want c3 1 0", data_out, out_valid, overrun); end
    n_tests++; if (edge_mism !== 0) begin n_fail++; $display("FAIL drain_edges: got %0d differing edges want 0", edge_mism); end
  endtask

  task automatic test_frame_err;
    int e0;
    edge_mism = 0;
    drive_frame(8'hFF, 4, 0, 1'b0, 1'b0, 0, e0);
    n_tests++; if (last_ferr_at !== e0 + 6) begin n_fail++; $display("FAIL ferr_edge: got E%0d want E6", last_ferr_at - e0); end
    n_tests++; if ({data_out, out_valid} !== {8'hC3, 1'b1}) begin
      n_fail++; $display("FAIL ferr_hold: got d=%h v=%b want c3 1", data_out, out_valid); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_pulse: got %b want 0", frame_err); end
    drive_frame(8'h81, 8, 1, 1'b0, 1'b0, 0, e0);
    n_tests++; if (last_done_at !== e0 + 9 || data_out !== 8'h81) begin
      n_fail++; $display("FAIL ferr_next: got d=%h at E%0d want 81 at E9", data_out, last_done_at - e0); end
    n_tests++; if (edge_mism !== 0) begin n_fail++; $display("FAIL ferr_edges: got %0d differing edges want 0", edge_mism); end
  endtask

  task automatic test_reset_mid;
    int e0;
    edge_mism = 0;
    drive_frame(8'h77, 5, 1, 1'b0, 1'b1, 0, e0);
    n_tests++; if ({data_out, out_valid, done, frame_err, overrun} !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid: got d=%h flags=%b want 0", data_out, {out_valid, done, frame_err, overrun}); end
    drive_frame(8'h5A, 8, 0, 1'b0, 1'b0, 0, e0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    n_tests++; if ({data_out, out_valid, done, frame_err, overrun} !== 12'h000) begin
      n_fail++; $display("FAIL rst_full: got d=%h flags=%b want 0", data_out, {out_valid, done, frame_err, overrun}); end
    drive_frame(8'h5A, 8, 1, 1'b0, 1'b0, 0, e0);
    n_tests++; if (last_done_at !== e0 + 9 || data_out !== 8'h5A) begin
      n_fail++; $display("FAIL rst_next: got d=%h at E%0d want 5a at E9", data_out, last_done_at - e0); end
    n_tests++; if (edge_mism !== 0) begin n_fail++; $display("FAIL rst_edges: got %0d differing edges want 0", edge_mism); end
  endtask

  task automatic test_random;
    int e0, nb, sel, exp_dones, done0;
    edge_mism = 0; exp_dones = 0; done0 = done_cnt;
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) nb = -1;
      else if (sel == 1) nb = $urandom_range(0, 7);
      else nb = 8;
      if (nb == 8) exp_dones++;
      drive_frame(8'($urandom), nb, 2, 1'b1, 1'b0, $urandom_range(0, 2), e0);
      for (int g = $urandom_range(0, 2); g > 0; g--)
        step(1'b0, 1'($urandom), 1'($urandom), pick_clr(1'b1), 1'b0, 1'b0, 1'b0, 8'h00);
    end
    n_tests++; if (done_cnt - done0 !== exp_dones) begin
      n_fail++; $display("FAIL rand_done_count: got %0d want %0d", done_cnt - done0, exp_dones); end
    n_tests++; if (edge_mism !== 0) begin n_fail++; $display("FAIL rand_edges: got %0d differing edges want 0", edge_mism); end
  endtask

  task automatic test_word16;
    logic [15:0] w;
    w = 16'hBEEF;
    start = 1'b0; out_ready = 1'b0; clr_err = 1'b0; reset = 1'b0;
    start16 = 1'b1; ready16 = 1'b1; clr16 = 1'b0; data16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      data16 = w[15-i];
      @(posedge clk); #1;
      if (i == 14) begin
        n_tests++; if (done16 !== 1'b0 || out_valid16 !== 1'b0) begin
          n_fail++; $display("FAIL w16_early: got done=%b v=%b at E16 want 0 0", done16, out_valid16); end
      end
    end
    n_tests++; if ({data_out16, out_valid16, done16, frame_err16, overrun16} !== {16'hBEEF, 4'b1100}) begin
      n_fail++; $display("FAIL w16_e17: got d=%h flags=%b want beef 1100", data_out16, {out_valid16, done16, frame_err16, overrun16}); end
    start16 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({done16, out_valid16} !== 2'b00) begin
      n_fail++; $display("FAIL w16_after: got done=%b v=%b want 0 0", done16, out_valid16); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_i = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    start16 = 1'b0; data16 = 1'b0; ready16 = 1'b0; clr16 = 1'b0;
    test_reset();
    test_loopback();
    test_overrun();
    test_drain_same_edge();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_word16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
